// File: rtl/sfif_pkg.sv
// Shared definitions for the SFIF RX packet queue: header layout, read-FSM encoding, counter width.
package sfif_pkg;
  localparam int TS_W       = 32;
  localparam int SEQ_W      = 16;
  localparam int DW_W       = 32;
  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {RD_IDLE, RD_HDR_TS, RD_HDR_LEN, RD_DATA} rd_state_e;
  typedef enum logic [1:0] {SRC_HDR, SRC_HI, SRC_LO} rd_src_e;

  // Header word packs {ts, seq, dw_len} with dw_len in the LSBs.
  function automatic int len_lsb(int len_w); return 0;                 endfunction
  function automatic int seq_lsb(int len_w); return len_w;             endfunction
  function automatic int ts_lsb(int len_w);  return len_w + SEQ_W;     endfunction
  function automatic int hdr_w(int len_w);   return len_w + SEQ_W + TS_W; endfunction
endpackage

// File: rtl/sfif_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO; push while full and pop while empty are ignored.
module sfif_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign full  = cnt_q[DEPTH_LOG2];
  assign empty = (cnt_q == '0);
  assign dout  = mem[rp_q];

  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    wp_d    = wp_q + DEPTH_LOG2'(do_push);
    rp_d    = rp_q + DEPTH_LOG2'(do_pop);
    cnt_d   = cnt_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp_q] <= din;
  end
endmodule

// File: rtl/sfif_rx_pktq.sv
// Packet-aware RX capture queue: 64-bit TLP beats in, header-prefixed 32-bit dword stream out.
// Define SFIF_RX_PKTQ_DROP_CNT_EN to build the saturating overflow-drop counter.
module sfif_rx_pktq
  import sfif_pkg::*;
#(
  parameter int DEPTH_LOG2     = 11,
  parameter int HDR_DEPTH_LOG2 = 5,
  parameter int LEN_W          = DEPTH_LOG2 + 2
) (
  input  logic                  clk_125,
  input  logic                  rst,
  input  logic [TS_W-1:0]       timestamp,
  input  logic                  rx64_st,
  input  logic                  rx64_end,
  input  logic                  rx64_dwen,
  input  logic [63:0]           rx64_data,
  input  logic                  rx64_filter,
  input  logic                  rden,
  output logic [DW_W-1:0]       rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  localparam int AW      = DEPTH_LOG2;
  localparam int HDR_W   = hdr_w(LEN_W);
  localparam int TS_LSB  = ts_lsb(LEN_W);
  localparam int SEQ_LSB = seq_lsb(LEN_W);
  localparam int LEN_LSB = len_lsb(LEN_W);

  logic [63:0]      ram [2**AW];
  logic [63:0]      ram_rdata_q;

  // write side
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, pkt_start_q, pkt_start_d;
  logic             open_q, open_d, filt_q, filt_d, drop_q, drop_d;
  logic [LEN_W-1:0] len_q, len_d, len_nxt;
  logic [TS_W-1:0]  ts_q, ts_d, ts_cur;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [AW-1:0]    base, start_cur;
  logic             in_pkt, beat_drop, ram_we, hdr_push, pkt_abort, end_drop;
  logic [1:0]       drop_inc;
  logic [HDR_W-1:0] hdr_din, hdr_dout;
  logic             hdr_full, hdr_empty, hdr_pop;

  // read side
  rd_state_e        st_q, st_d;
  rd_src_e          src_q, src_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0] rem_q, rem_d, rem_cur;
  logic             half_q, half_d, half_cur;
  logic [DW_W-1:0]  hdr_dw_q, hdr_dw_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_acc, ram_re, last;
  logic [TS_W-1:0]  hdr_ts;
  logic [SEQ_W-1:0] hdr_seq;
  logic [LEN_W-1:0] hdr_len;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    pkt_start_d = pkt_start_q;
    open_d      = open_q;
    filt_d      = filt_q;
    drop_d      = drop_q;
    len_d       = len_q;
    ts_d        = ts_q;
    seq_d       = seq_q;
    base        = wr_ptr_q;
    len_nxt     = len_q;
    beat_drop   = 1'b0;
    ram_we      = 1'b0;
    hdr_push    = 1'b0;
    hdr_din     = '0;
    pkt_abort   = 1'b0;
    end_drop    = 1'b0;

    if (rx64_st) begin
      // A new start while a packet is open discards the open one and reuses its space.
      if (open_q) begin
        pkt_abort = 1'b1;
        base      = pkt_start_q;
        wr_ptr_d  = pkt_start_q;
      end
      open_d      = ~rx64_filter;
      filt_d      = rx64_filter & ~rx64_end;
      drop_d      = 1'b0;
      len_d       = '0;
      ts_d        = timestamp;
      pkt_start_d = base;
    end else if (filt_q && rx64_end) begin
      filt_d = 1'b0;
    end

    start_cur = rx64_st ? base : pkt_start_q;
    ts_cur    = rx64_st ? timestamp : ts_q;
    in_pkt    = rx64_st ? ~rx64_filter : open_q;

    if (in_pkt) begin
      beat_drop = (~rx64_st & drop_q) | ((base + AW'(1)) == rd_ptr_q);
      len_nxt   = (rx64_st ? '0 : len_q) + ((rx64_end & rx64_dwen) ? LEN_W'(1) : LEN_W'(2));
      len_d     = len_nxt;
      drop_d    = beat_drop;
      if (!beat_drop) begin
        ram_we   = 1'b1;
        wr_ptr_d = base + AW'(1);
      end
      if (rx64_end) begin
        open_d = 1'b0;
        if (!beat_drop && !hdr_full) begin
          hdr_push = 1'b1;
          hdr_din  = {ts_cur, seq_q, len_nxt};
          seq_d    = seq_q + SEQ_W'(1);
        end else begin
          end_drop = 1'b1;
          wr_ptr_d = start_cur;
        end
      end
    end
    drop_inc = 2'(pkt_abort) + 2'(end_drop);
  end

  always_ff @(posedge clk_125) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      pkt_start_q <= '0;
      open_q      <= 1'b0;
      filt_q      <= 1'b0;
      drop_q      <= 1'b0;
      len_q       <= '0;
      ts_q        <= '0;
      seq_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      pkt_start_q <= pkt_start_d;
      open_q      <= open_d;
      filt_q      <= filt_d;
      drop_q      <= drop_d;
      len_q       <= len_d;
      ts_q        <= ts_d;
      seq_q       <= seq_d;
    end
  end

  always_ff @(posedge clk_125) begin
    if (ram_we) ram[base] <= rx64_data;
  end

  always_ff @(posedge clk_125) begin
    if (ram_re) ram_rdata_q <= ram[rd_ptr_q];
  end

  sfif_sync_fifo #(.WIDTH(HDR_W), .DEPTH_LOG2(HDR_DEPTH_LOG2)) u_hdr_q (
    .clk   (clk_125),
    .rst   (rst),
    .push  (hdr_push),
    .din   (hdr_din),
    .pop   (hdr_pop),
    .dout  (hdr_dout),
    .full  (hdr_full),
    .empty (hdr_empty)
  );

  assign hdr_ts  = hdr_dout[TS_LSB +: TS_W];
  assign hdr_seq = hdr_dout[SEQ_LSB +: SEQ_W];
  assign hdr_len = hdr_dout[LEN_LSB +: LEN_W];

  // State names the dword most recently returned; the header stays at the queue head until popped.
  always_comb begin
    st_d       = st_q;
    src_d      = src_q;
    rd_ptr_d   = rd_ptr_q;
    rem_d      = rem_q;
    half_d     = half_q;
    hdr_dw_d   = hdr_dw_q;
    ram_re     = 1'b0;
    hdr_pop    = 1'b0;
    last       = 1'b0;
    rd_acc     = rden & (~hdr_empty | (st_q != RD_IDLE));
    rd_valid_d = rd_acc;
    rem_cur    = (st_q == RD_HDR_LEN) ? hdr_len : rem_q;
    half_cur   = (st_q == RD_HDR_LEN) ? 1'b0 : half_q;

    if (rd_acc) begin
      case (st_q)
        RD_IDLE: begin
          src_d    = SRC_HDR;
          hdr_dw_d = hdr_ts;
          st_d     = RD_HDR_TS;
        end
        RD_HDR_TS: begin
          src_d    = SRC_HDR;
          hdr_dw_d = {hdr_seq, 16'(hdr_len)};
          st_d     = RD_HDR_LEN;
        end
        default: begin
          st_d   = RD_DATA;
          last   = (rem_cur == LEN_W'(1));
          rem_d  = rem_cur - LEN_W'(1);
          half_d = ~half_cur;
          if (half_cur) begin
            src_d = SRC_LO;
          end else begin
            src_d  = SRC_HI;
            ram_re = 1'b1;
          end
          // Leaving an entry after its low dword, or after a lone high dword of a dwen packet.
          if (half_cur || last) rd_ptr_d = rd_ptr_q + AW'(1);
          if (last) begin
            hdr_pop = 1'b1;
            half_d  = 1'b0;
            st_d    = RD_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_125) begin
    if (rst) begin
      st_q       <= RD_IDLE;
      src_q      <= SRC_HDR;
      rd_ptr_q   <= '0;
      rem_q      <= '0;
      half_q     <= 1'b0;
      hdr_dw_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      src_q      <= src_d;
      rd_ptr_q   <= rd_ptr_d;
      rem_q      <= rem_d;
      half_q     <= half_d;
      hdr_dw_q   <= hdr_dw_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    case (src_q)
      SRC_HI:  rd_data = ram_rdata_q[63:32];
      SRC_LO:  rd_data = ram_rdata_q[31:0];
      default: rd_data = hdr_dw_q;
    endcase
  end

  assign rd_valid = rd_valid_q;
  assign empty    = hdr_empty;

`ifdef SFIF_RX_PKTQ_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DROP_CNT_W:0]   drop_sum;

  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + (DROP_CNT_W+1)'(drop_inc);
    drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end

  always_ff @(posedge clk_125) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop_inc;
  assign unused_drop_inc = ^drop_inc;
  assign drop_cnt        = '0;
`endif
endmodule

// File: tb/tb_sfif_rx_pktq.sv
// Scoreboard bench for sfif_rx_pktq: directed packets queue expected dwords, a monitor checks reads.
module tb_sfif_rx_pktq;
  logic        clk_125 = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] timestamp = '0;
  logic        rx64_st = 1'b0, rx64_end = 1'b0, rx64_dwen = 1'b0, rx64_filter = 1'b0, rden = 1'b0;
  logic [63:0] rx64_data = '0;
  logic [31:0] rd_data;
  logic        rd_valid, empty;
  logic [15:0] drop_cnt;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

`ifdef SFIF_RX_PKTQ_DROP_CNT_EN
  localparam logic [31:0] CNT_EN = 32'd1;
`else
  localparam logic [31:0] CNT_EN = 32'd0;
`endif

  always #4 clk_125 = ~clk_125;

  sfif_rx_pktq #(.DEPTH_LOG2(4), .HDR_DEPTH_LOG2(3), .LEN_W(6)) dut (
    .clk_125     (clk_125),
    .rst         (rst),
    .timestamp   (timestamp),
    .rx64_st     (rx64_st),
    .rx64_end    (rx64_end),
    .rx64_dwen   (rx64_dwen),
    .rx64_data   (rx64_data),
    .rx64_filter (rx64_filter),
    .rden        (rden),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .drop_cnt    (drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk_125) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected actual=%h expected=none", rd_data);
      end else begin
        chk("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_125);
    #1;
  endtask

  task automatic idle();
    rx64_st = 1'b0; rx64_end = 1'b0; rx64_dwen = 1'b0; rx64_filter = 1'b0; rx64_data = '0;
  endtask

  // Beat i carries {base+2i, base+2i+1}; timestamp moves every beat so only the st sample is right.
  task automatic send_pkt(input int n, input logic [31:0] ts, input logic [31:0] base,
                          input bit dwen, input bit filt, input bit noend);
    logic [31:0] hi;
    for (int i = 0; i < n; i++) begin
      hi          = base + 32'(2 * i);
      rx64_st     = (i == 0);
      rx64_end    = (i == n - 1) && !noend;
      rx64_dwen   = dwen && (i == n - 1);
      rx64_filter = filt && (i == 0);
      timestamp   = ts + 32'(i);
      rx64_data   = {hi, hi + 32'd1};
      tick();
    end
  endtask

  task automatic expect_pkt(input int n, input logic [31:0] ts, input logic [15:0] seq,
                            input logic [31:0] base, input bit dwen);
    int len;
    len = 2 * n - (dwen ? 1 : 0);
    exp_q.push_back(ts);
    exp_q.push_back({seq, 16'(len)});
    for (int k = 0; k < len; k++) exp_q.push_back(base + 32'(k));
  endtask

  task automatic read_words(input int n);
    for (int i = 0; i < n; i++) begin
      rden = 1'b1;
      tick();
    end
    rden = 1'b0;
    tick();
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) tick();
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rden = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);

    // 1: single 3-beat packet
    send_pkt(3, 32'h100, 32'h1000, 0, 0, 0);
    expect_pkt(3, 32'h100, 16'd0, 32'h1000, 0);
    idle(); tick();
    chk("t1_not_empty", 32'(empty), 32'h0);
    read_words(8);
    drain("t1_drain");
    chk("t1_empty_after", 32'(empty), 32'h1);

    // 2: dwen packet then a single-beat packet back to back
    send_pkt(2, 32'h200, 32'h2000, 1, 0, 0);
    send_pkt(1, 32'h300, 32'h3000, 0, 0, 0);
    expect_pkt(2, 32'h200, 16'd1, 32'h2000, 1);
    expect_pkt(1, 32'h300, 16'd2, 32'h3000, 0);
    idle(); tick();
    read_words(9);
    drain("t2_drain");
    chk("t2_empty_after", 32'(empty), 32'h1);
    rden = 1'b1; tick(); rden = 1'b0;
    chk("t2_rden_empty_valid", 32'(rd_valid), 32'h0);
    tick();

    // 3: filtered packet leaves nothing and does not consume a sequence number
    send_pkt(4, 32'h400, 32'h4000, 0, 1, 0);
    idle(); tick();
    chk("t3_empty", 32'(empty), 32'h1);
    send_pkt(1, 32'h500, 32'h5000, 0, 0, 0);
    expect_pkt(1, 32'h500, 16'd3, 32'h5000, 0);
    idle(); tick();
    read_words(4);
    drain("t3_drain");

    // 4: 20-beat packet overflows a 16-entry RAM and is dropped
    do_reset();
    chk("t4_rst_drop_cnt", 32'(drop_cnt), 32'h0);
    send_pkt(20, 32'h600, 32'h6000, 0, 0, 0);
    idle(); tick();
    chk("t4_empty", 32'(empty), 32'h1);
    chk("t4_drop_cnt", 32'(drop_cnt), CNT_EN);
    send_pkt(2, 32'h700, 32'h7000, 0, 0, 0);
    expect_pkt(2, 32'h700, 16'd0, 32'h7000, 0);
    idle(); tick();
    read_words(6);
    drain("t4_drain");

    // 5: back-to-back packets, the second wrapping through address 0
    send_pkt(8, 32'h800, 32'h8000, 0, 0, 0);
    send_pkt(7, 32'h900, 32'h9000, 1, 0, 0);
    expect_pkt(8, 32'h800, 16'd1, 32'h8000, 0);
    expect_pkt(7, 32'h900, 16'd2, 32'h9000, 1);
    idle(); tick();
    read_words(33);
    drain("t5_drain");

    // 5b: start while a packet is open drops the open one
    send_pkt(2, 32'hA00, 32'hA000, 0, 0, 1);
    send_pkt(2, 32'hB00, 32'hB000, 0, 0, 0);
    expect_pkt(2, 32'hB00, 16'd3, 32'hB000, 0);
    idle(); tick();
    chk("t5b_drop_cnt", 32'(drop_cnt), 32'(2) * CNT_EN);
    read_words(6);
    drain("t5b_drain");

    // 6: reset mid-packet and mid-read
    send_pkt(2, 32'hC00, 32'hC000, 0, 0, 0);
    exp_q.push_back(32'hC00);
    exp_q.push_back({16'd4, 16'd4});
    exp_q.push_back(32'hC000);
    for (int i = 0; i < 3; i++) begin
      rden        = 1'b1;
      rx64_st     = (i == 0);
      rx64_end    = 1'b0;
      timestamp   = 32'hE00 + 32'(i);
      rx64_data   = {32'hE000 + 32'(i), 32'hEEEE};
      tick();
    end
    rden = 1'b0;
    do_reset();
    chk("t6_empty", 32'(empty), 32'h1);
    chk("t6_rd_valid", 32'(rd_valid), 32'h0);
    chk("t6_rd_data", rd_data, 32'h0);
    chk("t6_drop_cnt", 32'(drop_cnt), 32'h0);
    chk("t6_pending", 32'(exp_q.size()), 32'd0);
    send_pkt(1, 32'hD00, 32'hD000, 0, 0, 0);
    expect_pkt(1, 32'hD00, 16'd0, 32'hD000, 0);
    idle(); tick();
    read_words(4);
    drain("t6_drain");
    chk("t6_empty_after", 32'(empty), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
